// File: rtl/execute_stage_unit_if.sv
// execute_stage_unit_if: decoded-instruction inputs and registered execute results; ADDR_MISALIGN_CHECK_EN adds misaligned
interface execute_stage_unit_if #(parameter int XLEN = 32);
  logic            valid_in;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [2:0]      instruction_type;
  logic [4:0]      write_index;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] immediate;
  logic            valid_out;
  logic [XLEN-1:0] alu_output;
  logic [XLEN-1:0] address;
  logic            branch_taken;
  logic            address_type;
  logic            mux1_select;
  logic [1:0]      mux2_select;
  logic            lsu_enable;
  logic            read_enable_1;
  logic            read_enable_2;
  logic            write_enable;
  logic            writeback_output_select;
  logic            illegal;
`ifdef ADDR_MISALIGN_CHECK_EN
  logic            misaligned;
`endif
  modport master (
    output valid_in, opcode, funct3, funct7, instruction_type, write_index, PC, rs1, rs2, immediate,
`ifdef ADDR_MISALIGN_CHECK_EN
    input misaligned,
`endif
    input valid_out, alu_output, address, branch_taken, address_type, mux1_select, mux2_select,
          lsu_enable, read_enable_1, read_enable_2, write_enable, writeback_output_select, illegal
  );
  modport slave (
    input valid_in, opcode, funct3, funct7, instruction_type, write_index, PC, rs1, rs2, immediate,
`ifdef ADDR_MISALIGN_CHECK_EN
    output misaligned,
`endif
    output valid_out, alu_output, address, branch_taken, address_type, mux1_select, mux2_select,
           lsu_enable, read_enable_1, read_enable_2, write_enable, writeback_output_select, illegal
  );
endinterface

// File: rtl/execute_stage_unit.sv
// execute_stage_unit: RV32I decode, ALU, address generation and branch decision, all registered; ADDR_MISALIGN_CHECK_EN adds alignment checking
module execute_stage_unit #(parameter int XLEN = 32) (
  input logic CLK,
  input logic reset_n,
  execute_stage_unit_if.slave bus
);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111,
                         AUIPC = 7'b0010111;
  logic m1, at, lsu, re1, re2, we, wsel, ill_op, ill, bt, cond, sub, mis;
  logic [1:0] m2;
  logic [XLEN-1:0] a, b, sum, arith, alu, taddr, addr;
  logic unused;
  assign unused = ^{bus.instruction_type, bus.funct7[6], bus.funct7[4:0]};
  always_comb begin
    {m1, m2, at, lsu, re1, re2, we, wsel, ill_op} = '0;
    case (bus.opcode)
      OP:      {re1, re2, we} = 3'b111;
      OP_IMM:  {m2, re1, we} = 4'b01_1_1;
      LOAD:    {m2, at, re1, lsu, wsel, we} = 7'b01_1_1_1_1_1;
      STORE:   {m2, at, re1, re2, lsu} = 6'b01_1_1_1_1;
      BRANCH:  {re1, re2} = 2'b11;
      JAL:     {m1, m2, we} = 4'b1_10_1;
      JALR:    {m1, m2, at, re1, we} = 6'b1_10_1_1_1;
      LUI:     {m2, we} = 3'b01_1;
      AUIPC:   {m1, m2, we} = 4'b1_01_1;
      default: ill_op = 1'b1;
    endcase
  end
  assign a   = m1 ? bus.PC : bus.rs1;
  assign b   = m2[1] ? XLEN'(4) : m2[0] ? bus.immediate : bus.rs2;
  assign sum = a + b;
  assign sub = bus.opcode == OP && bus.funct7[5];
  always_comb begin
    case (bus.funct3)
      3'b000:  arith = sub ? a - b : sum;
      3'b001:  arith = a << b[4:0];
      3'b010:  arith = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      3'b011:  arith = {{(XLEN-1){1'b0}}, a < b};
      3'b100:  arith = a ^ b;
      3'b101:  arith = bus.funct7[5] ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  arith = a | b;
      default: arith = a & b;
    endcase
  end
  assign alu = (bus.opcode == OP || bus.opcode == OP_IMM) ? arith :
               bus.opcode == LUI ? bus.immediate :
               (bus.opcode == AUIPC || bus.opcode == JAL || bus.opcode == JALR || bus.opcode == LOAD) ? sum :
               bus.opcode == STORE ? bus.rs2 : '0;
  assign taddr = (at ? bus.rs1 : bus.PC) + bus.immediate;
  assign addr  = ill_op ? '0 : bus.opcode == JALR ? {taddr[XLEN-1:1], 1'b0} : taddr;
  always_comb begin
    case (bus.funct3)
      3'b000:  cond = bus.rs1 == bus.rs2;
      3'b001:  cond = bus.rs1 != bus.rs2;
      3'b100:  cond = $signed(bus.rs1) < $signed(bus.rs2);
      3'b101:  cond = $signed(bus.rs1) >= $signed(bus.rs2);
      3'b110:  cond = bus.rs1 < bus.rs2;
      3'b111:  cond = bus.rs1 >= bus.rs2;
      default: cond = 1'b0;
    endcase
  end
  assign bt  = bus.opcode == BRANCH ? cond : (bus.opcode == JAL || bus.opcode == JALR);
  assign ill = ill_op || (bus.opcode == BRANCH && bus.funct3[2:1] == 2'b01);
`ifdef ADDR_MISALIGN_CHECK_EN
  assign mis = ((bus.opcode == LOAD || bus.opcode == STORE) &&
                ((bus.funct3[1:0] == 2'b01 && addr[0]) || (bus.funct3[1:0] == 2'b10 && |addr[1:0]))) ||
               ((bus.opcode == JAL || bus.opcode == JALR || (bus.opcode == BRANCH && bt)) && |addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      bus.valid_out <= 1'b0;
      bus.alu_output <= '0;
      bus.address <= '0;
      bus.branch_taken <= 1'b0;
      bus.address_type <= 1'b0;
      bus.mux1_select <= 1'b0;
      bus.mux2_select <= 2'b00;
      bus.lsu_enable <= 1'b0;
      bus.read_enable_1 <= 1'b0;
      bus.read_enable_2 <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.writeback_output_select <= 1'b0;
      bus.illegal <= 1'b0;
`ifdef ADDR_MISALIGN_CHECK_EN
      bus.misaligned <= 1'b0;
`endif
    end else begin
      bus.valid_out <= bus.valid_in;
      if (bus.valid_in) begin
        bus.alu_output <= alu;
        bus.address <= addr;
        bus.branch_taken <= bt;
        bus.address_type <= at;
        bus.mux1_select <= m1;
        bus.mux2_select <= m2;
        bus.lsu_enable <= lsu && !mis;
        bus.read_enable_1 <= re1;
        bus.read_enable_2 <= re2;
        bus.write_enable <= we && |bus.write_index && !mis;
        bus.writeback_output_select <= wsel;
        bus.illegal <= ill;
`ifdef ADDR_MISALIGN_CHECK_EN
        bus.misaligned <= mis;
`endif
      end
    end
  end
endmodule

// File: tb/tb_execute_stage_unit.sv
// tb_execute_stage_unit: directed vector table plus reset and hold sequences for execute_stage_unit
module tb_execute_stage_unit;
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, failures = 0;
  execute_stage_unit_if #(.XLEN(32)) bus ();
  execute_stage_unit #(.XLEN(32)) dut (.CLK(CLK), .reset_n(reset_n), .bus(bus));
  always #5 CLK = ~CLK;
  // ctl packs {branch_taken, address_type, mux1, mux2[1:0], lsu, rd1, rd2, write, wsel, illegal}
  typedef struct {
    string name;
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [4:0] rd;
    logic [31:0] pc, r1, r2, imm, alu, addr;
    logic [10:0] ctl;
  } vec_t;
  vec_t q[$];
  logic [10:0] ctl;
  logic [31:0] last_alu, last_addr;
  logic [10:0] last_ctl;
  assign ctl = {bus.branch_taken, bus.address_type, bus.mux1_select, bus.mux2_select, bus.lsu_enable,
                bus.read_enable_1, bus.read_enable_2, bus.write_enable, bus.writeback_output_select, bus.illegal};
  task automatic add(input string n, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] rd, input logic [31:0] pc, r1, r2, imm, alu, addr, input logic [10:0] c);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.pc = pc; v.r1 = r1; v.r2 = r2;
    v.imm = imm; v.alu = alu; v.addr = addr; v.ctl = c;
    q.push_back(v);
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t v, input logic vin);
    @(negedge CLK);
    bus.valid_in = vin; bus.opcode = v.op; bus.funct3 = v.f3; bus.funct7 = v.f7;
    bus.instruction_type = 3'd1; bus.write_index = v.rd; bus.PC = v.pc;
    bus.rs1 = v.r1; bus.rs2 = v.r2; bus.immediate = v.imm;
  endtask
  task automatic run(input vec_t v);
    drive(v, 1'b1);
    @(posedge CLK); #1;
    chk({v.name, " valid"}, 32'(bus.valid_out), 32'd1);
    chk({v.name, " alu"}, bus.alu_output, v.alu);
    chk({v.name, " addr"}, bus.address, v.addr);
    chk({v.name, " ctl"}, 32'(ctl), 32'(v.ctl));
  endtask
  initial begin
    bus.valid_in = 0; bus.opcode = 0; bus.funct3 = 0; bus.funct7 = 0; bus.instruction_type = 0;
    bus.write_index = 0; bus.PC = 0; bus.rs1 = 0; bus.rs2 = 0; bus.immediate = 0;
    add("add",   7'b0110011, 3'b000, 7'h00, 5'd1, 32'h0,    32'd5,        32'd7,    32'h0,        32'd12,       32'h0,    11'b0_0_0_00_0_1_1_1_0_0);
    add("sub",   7'b0110011, 3'b000, 7'h20, 5'd1, 32'h0,    32'd3,        32'd5,    32'h0,        32'hFFFFFFFE, 32'h0,    11'b0_0_0_00_0_1_1_1_0_0);
    add("srai",  7'b0010011, 3'b101, 7'h20, 5'd2, 32'h0,    32'h80000000, 32'h0,    32'd4,        32'hF8000000, 32'h4,    11'b0_0_0_01_0_1_0_1_0_0);
    add("srl",   7'b0110011, 3'b101, 7'h00, 5'd2, 32'h0,    32'h80000000, 32'd4,    32'h0,        32'h08000000, 32'h0,    11'b0_0_0_00_0_1_1_1_0_0);
    add("slt",   7'b0110011, 3'b010, 7'h00, 5'd3, 32'h0,    32'hFFFFFFFF, 32'd1,    32'h0,        32'h1,        32'h0,    11'b0_0_0_00_0_1_1_1_0_0);
    add("sltu",  7'b0110011, 3'b011, 7'h00, 5'd3, 32'h0,    32'hFFFFFFFF, 32'd1,    32'h0,        32'h0,        32'h0,    11'b0_0_0_00_0_1_1_1_0_0);
    add("xor",   7'b0110011, 3'b100, 7'h00, 5'd3, 32'h0,    32'hF0,       32'hFF,   32'h0,        32'h0F,       32'h0,    11'b0_0_0_00_0_1_1_1_0_0);
    add("load",  7'b0000011, 3'b010, 7'h00, 5'd4, 32'h0,    32'h1000,     32'h0,    32'hFFFFFFFC, 32'h0FFC,     32'h0FFC, 11'b0_1_0_01_1_1_0_1_1_0);
    add("store", 7'b0100011, 3'b010, 7'h00, 5'd5, 32'h0,    32'h1000,     32'hDEAD, 32'hFFFFFFFC, 32'hDEAD,     32'h0FFC, 11'b0_1_0_01_1_1_1_0_0_0);
    add("jalr",  7'b1100111, 3'b000, 7'h00, 5'd1, 32'h100,  32'h203,      32'h0,    32'h0,        32'h104,      32'h202,  11'b1_1_1_10_0_1_0_1_0_0);
    add("jal",   7'b1101111, 3'b000, 7'h00, 5'd1, 32'h1000, 32'h0,        32'h0,    32'h20,       32'h1004,     32'h1020, 11'b1_0_1_10_0_0_0_1_0_0);
    add("blt",   7'b1100011, 3'b100, 7'h00, 5'd0, 32'h40,   32'hFFFFFFFF, 32'd1,    32'hFFFFFFF8, 32'h0,        32'h38,   11'b1_0_0_00_0_1_1_0_0_0);
    add("bltu",  7'b1100011, 3'b110, 7'h00, 5'd0, 32'h40,   32'hFFFFFFFF, 32'd1,    32'hFFFFFFF8, 32'h0,        32'h38,   11'b0_0_0_00_0_1_1_0_0_0);
    add("beq",   7'b1100011, 3'b000, 7'h00, 5'd0, 32'h10,   32'd7,        32'd7,    32'h8,        32'h0,        32'h18,   11'b1_0_0_00_0_1_1_0_0_0);
    add("br010", 7'b1100011, 3'b010, 7'h00, 5'd0, 32'h10,   32'd7,        32'd7,    32'h8,        32'h0,        32'h18,   11'b0_0_0_00_0_1_1_0_0_1);
    add("lui",   7'b0110111, 3'b000, 7'h00, 5'd3, 32'h0,    32'h0,        32'h0,    32'h12345000, 32'h12345000, 32'h12345000, 11'b0_0_0_01_0_0_0_1_0_0);
    add("auipc", 7'b0010111, 3'b000, 7'h00, 5'd3, 32'h1000, 32'h0,        32'h0,    32'h2000,     32'h3000,     32'h3000, 11'b0_0_1_01_0_0_0_1_0_0);
    add("addi0", 7'b0010011, 3'b000, 7'h00, 5'd0, 32'h0,    32'd10,       32'h0,    32'd5,        32'd15,       32'h5,    11'b0_0_0_01_0_1_0_0_0_0);
    add("wrap",  7'b0010011, 3'b000, 7'h00, 5'd2, 32'h0,    32'hFFFFFFFC, 32'h0,    32'd8,        32'h4,        32'h8,    11'b0_0_0_01_0_1_0_1_0_0);
    add("ill",   7'b1111111, 3'b000, 7'h00, 5'd1, 32'h40,   32'd1,        32'd2,    32'h8,        32'h0,        32'h0,    11'b0_0_0_00_0_0_0_0_0_1);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst valid", 32'(bus.valid_out), 32'd0);
    chk("rst alu", bus.alu_output, 32'h0);
    chk("rst addr", bus.address, 32'h0);
    chk("rst ctl", 32'(ctl), 32'h0);
    @(negedge CLK);
    reset_n = 1'b1;
    foreach (q[i]) run(q[i]);
    last_alu = bus.alu_output; last_addr = bus.address; last_ctl = ctl;
    drive(q[0], 1'b0);
    @(posedge CLK); #1;
    chk("hold valid", 32'(bus.valid_out), 32'd0);
    chk("hold alu", bus.alu_output, q[q.size()-1].alu);
    chk("hold addr", bus.address, q[q.size()-1].addr);
    chk("hold ctl", 32'(ctl), 32'(q[q.size()-1].ctl));
    run(q[0]);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async valid", 32'(bus.valid_out), 32'd0);
    chk("async alu", bus.alu_output, 32'h0);
    chk("async ctl", 32'(ctl), 32'h0);
    @(negedge CLK);
    reset_n = 1'b1;
    run(q[0]);
    @(negedge CLK);
    bus.valid_in = 1'b0;
    @(posedge CLK); #1;
    chk("post valid", 32'(bus.valid_out), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
